// File: rtl/rom_loader_pkg.sv
// Shared types for the program loader: error codes, FSM states, helper predicates.
// Pure declarations; no latency or backpressure of its own.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        LOAD_NONE         = 3'd0,
        LOAD_TOO_LONG     = 3'd1,
        LOAD_BAD_CHECKSUM = 3'd2
    } load_err_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam int LEN_W = 17;

    function automatic logic state_accepts(input state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte stream in (valid/ready) and program-memory write port out, bundled together.
// Wiring only; master is the host side, slave is the loader.
interface rom_loader_if #(
    parameter int ROM_ADDR = 4
) ();
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [ROM_ADDR-1:0] mem_addr;
    logic [7:0]          mem_data;
    logic                mem_we;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_data, mem_we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/rom_loader.sv
// Framed byte-stream loader (len lo/hi, payload, xor checksum) into program memory; holds CPU in reset until DONE.
// Latency: payload write strobe one cycle after the byte transfer; done/error one cycle after the checksum byte.
// Backpressure: in_ready is combinational from state, high only while a frame is being received.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ROM_ADDR = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    rom_loader_if.slave  bus,
    output logic         cpu_reset,
    output logic         done,
    output logic [2:0]   error
);

    localparam int             IDX_W = ROM_ADDR + 1;
    localparam logic [LEN_W-1:0] CAP = LEN_W'(1) << ROM_ADDR;

    state_e              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          xor_q, xor_d;
    logic                we_q, we_d;
    logic [ROM_ADDR-1:0] addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                done_q, done_d;
    load_err_e           err_q, err_d;

    logic                xfer;
    logic [LEN_W-1:0]    n_full;
    logic [LEN_W-1:0]    idx_inc;

    assign bus.in_ready = reset && state_accepts(state_q);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign n_full       = {1'b0, bus.in_data, len_lo_q};
    assign idx_inc      = LEN_W'(idx_q) + LEN_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            xor_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= LOAD_NONE;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_LO;
                    done_d  = 1'b0;
                    err_d   = LOAD_NONE;
                    xor_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = bus.in_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d = n_full;
                    // N equal to capacity is legal: the index has one spare bit.
                    if (n_full > CAP) begin
                        state_d = ST_ERROR;
                        err_d   = LOAD_TOO_LONG;
                    end else if (n_full == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    we_d   = 1'b1;
                    addr_d = idx_q[ROM_ADDR-1:0];
                    data_d = bus.in_data;
                    xor_d  = xor_q ^ bus.in_data;
                    idx_d  = idx_inc[IDX_W-1:0];
                    if (idx_inc == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (bus.in_data == xor_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = LOAD_BAD_CHECKSUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign cpu_reset    = (state_q != ST_DONE);
    assign done         = done_q;
    assign error        = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed frames against rom_loader with a write/outcome scoreboard checked by a negedge monitor.
// Stimulus pushes expectations; the monitor pops on every mem_we and on each new done/error.
module tb_rom_loader;
    import rom_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       cpu_reset;
    logic       done;
    logic [2:0] error;

    rom_loader_if #(.ROM_ADDR(4)) bus ();

    rom_loader #(.ROM_ADDR(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [11:0] wr_q[$];
    logic [4:0]  res_q[$];
    logic [7:0]  fr[$];
    logic        gap_mode = 1'b0;
    logic        res_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        logic [11:0] w;
        logic [4:0]  r;
        logic        flag;
        if (bus.mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.mem_addr, bus.mem_data);
            end else begin
                w = wr_q.pop_front();
                check("mem_write", 32'({bus.mem_addr, bus.mem_data}), 32'(w));
            end
        end
        flag = (done === 1'b1) || (error !== 3'd0);
        if (flag && !res_seen) begin
            if (res_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_outcome: done %0b error %0d", done, error);
            end else begin
                r = res_q.pop_front();
                check("outcome{done,error,cpu_reset}", 32'({done, error, cpu_reset}), 32'(r));
            end
        end
        res_seen = flag;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: byte %0h never accepted, in_ready %0b", b, bus.in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h5A;
        if (gap_mode) idle(1);
    endtask

    task automatic send_frame();
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic push_normal();
        wr_q.push_back({4'h0, 8'h00});
        wr_q.push_back({4'h1, 8'h61});
        wr_q.push_back({4'h2, 8'h73});
        res_q.push_back({1'b1, 3'd0, 1'b0});
        fr = '{8'h03, 8'h00, 8'h00, 8'h61, 8'h73, 8'h12};
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),   32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_data"},  32'(bus.mem_data), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset),    32'd1);
        check({tag, "_done"},      32'(done),         32'd0);
        check({tag, "_error"},     32'(error),        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        idle(2);
        check_reset_values("reset");
        reset = 1'b1;
        idle(1);
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // Normal load
        push_normal();
        pulse_start();
        send_frame();
        idle(2);
        check("normal_done", 32'(done), 32'd1);
        check("normal_cpu_reset", 32'(cpu_reset), 32'd0);

        // Reload with an exact 16-byte fill
        pulse_start();
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload_done_cleared", 32'(done), 32'd0);
        fr = '{8'h10, 8'h00};
        for (int i = 0; i < 16; i++) begin
            wr_q.push_back({4'(i), 8'(8'h10 + i)});
            fr.push_back(8'(8'h10 + i));
        end
        fr.push_back(8'h00);
        res_q.push_back({1'b1, 3'd0, 1'b0});
        send_frame();
        idle(2);
        check("fill_done", 32'(done), 32'd1);

        // Overflow by one
        res_q.push_back({1'b0, 3'd1, 1'b1});
        pulse_start();
        fr = '{8'h11, 8'h00};
        send_frame();
        check("too_long_error", 32'(error), 32'd1);
        check("too_long_in_ready", 32'(bus.in_ready), 32'd0);
        idle(2);
        check("too_long_in_ready_hold", 32'(bus.in_ready), 32'd0);

        // Bad checksum
        wr_q.push_back({4'h0, 8'hAA});
        res_q.push_back({1'b0, 3'd2, 1'b1});
        pulse_start();
        fr = '{8'h01, 8'h00, 8'hAA, 8'hAB};
        send_frame();
        idle(2);
        check("bad_csum_cpu_reset", 32'(cpu_reset), 32'd1);

        // Zero length
        res_q.push_back({1'b1, 3'd0, 1'b0});
        pulse_start();
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame();
        idle(2);

        // Normal load with in_valid gaps
        gap_mode = 1'b1;
        push_normal();
        pulse_start();
        send_frame();
        gap_mode = 1'b0;
        idle(2);

        // Reset after the second payload byte has been written
        wr_q.push_back({4'h0, 8'h00});
        wr_q.push_back({4'h1, 8'h61});
        pulse_start();
        fr = '{8'h03, 8'h00, 8'h00, 8'h61};
        send_frame();
        idle(1);
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        idle(2);
        reset = 1'b1;
        idle(1);
        push_normal();
        pulse_start();
        send_frame();
        idle(3);

        check("writes_outstanding", 32'(wr_q.size()), 32'd0);
        check("outcomes_outstanding", 32'(res_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
